// File: rtl/hwpe_engine_outcnt_mc.sv
// Output-beat counter and job sequencer for a multi-stream HWPE engine.
// Optional DRAIN watchdog enabled by defining HWPE_OUTCNT_WATCHDOG_EN.
module hwpe_engine_outcnt_mc #(
    parameter int unsigned N_OUT      = 2,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic                   kernel_ready_i,
    input  logic                   kernel_idle_i,
    input  logic                   kernel_done_i,
    input  logic [N_OUT-1:0]       out_valid_i,
    input  logic [N_OUT-1:0]       out_ready_i,
    input  logic [N_OUT*CNT_W-1:0] expected_i,
    output logic                   kernel_start_o,
    output logic                   ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [N_OUT*CNT_W-1:0] cnt_o,
    output logic                   overflow_o,
    output logic                   timeout_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    if (N_OUT < 1 || N_OUT > 8 || WDOG_LIMIT < 1) begin : g_bad_cfg
        $error("hwpe_engine_outcnt_mc: unsupported parameter set");
    end

    logic [1:0]                  state_q, state_d;
    logic                        ready_q;
    logic                        ovf_q;
    logic [N_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_OUT-1:0]            hs, sat;
    logic                        counting, any_hs, all_sat;
    logic                        accept, ovf_hit, wdog_fire;

    assign counting = (state_q == RUN) || (state_q == DRAIN);
    assign hs       = out_valid_i & out_ready_i;
    assign any_hs   = counting && (|hs);
    assign accept   = (state_q == IDLE) && start_i && ready_q;
    assign all_sat  = &sat;

    // Satisfaction uses the post-increment value so the last beat closes the job.
    always_comb begin
        cnt_d   = cnt_q;
        sat     = '0;
        ovf_hit = 1'b0;
        for (int k = 0; k < int'(N_OUT); k++) begin
            if (counting && hs[k]) begin
                if (cnt_q[k] == {CNT_W{1'b1}}) begin
                    ovf_hit = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_W'(1);
                end
            end
            sat[k] = cnt_d[k] >= expected_i[k*CNT_W +: CNT_W];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = RUN;
            end
            RUN: begin
                if (kernel_done_i) state_d = all_sat ? DONE : DRAIN;
            end
            DRAIN: begin
                if (all_sat || wdog_fire) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_q == IDLE) && (kernel_ready_i || kernel_idle_i);
            if (accept) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                if (ovf_hit) ovf_q <= 1'b1;
            end
        end
    end

`ifdef HWPE_OUTCNT_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WDOG_LIMIT + 1);

    logic [WD_W-1:0] wdog_q, wdog_inc;
    logic            tmo_q;

    assign wdog_inc  = wdog_q + WD_W'(1);
    assign wdog_fire = (state_q == DRAIN) && !any_hs && !all_sat
                     && (wdog_inc == WD_W'(WDOG_LIMIT));

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            wdog_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            if (state_q != DRAIN || any_hs) begin
                wdog_q <= '0;
            end else begin
                wdog_q <= wdog_inc;
            end
            if (accept) begin
                tmo_q <= 1'b0;
            end else if (wdog_fire) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign timeout_o = tmo_q;
`else
    assign wdog_fire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign kernel_start_o = accept && rst_ni && !clear_i;
    assign ready_o        = ready_q;
    assign busy_o         = counting;
    assign done_o         = (state_q == DONE);
    assign cnt_o          = cnt_q;
    assign overflow_o     = ovf_q;

endmodule
